hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Pipeline hazard and sequencing controller for the 5-stage MIPS core. It produces the IF/ID hold (loadad) and flush (jumpSuccess) controls, the PC hold and the ID/EX bubble. Hazard sources are load-use dependences, taken branches/jumps, and a multi-cycle multiply/divide unit (MDU) whose busy window it tracks with an internal counter. It sits beside IF/ID and ID/EX and is the only block that drives their hold and flush inputs.

Parameters:
MDU_LAT, 4, MDU latency in cycles from accepted start to HI/LO valid; legal range 2..15
PERF_W, 16, width of the saturating stall-cycle performance counter

Ports:
clk  in  1  core clock; all state changes on posedge
rst  in  1  asynchronous reset, active-high
id_rs  in  5  rs field of instruction in ID
id_rt  in  5  rt field of instruction in ID
id_use_rs  in  1  ID instruction reads rs
id_use_rt  in  1  ID instruction reads rt
id_jump  in  1  ID holds j/jal/jr (target resolved in ID)
id_mdu_start  in  1  ID holds mult/div
id_mdu_read  in  1  ID holds mfhi/mflo
ex_load  in  1  EX holds a load (MentoReg=1 and RegWr=1)
ex_wreg  in  5  destination register of EX instruction
ex_br_taken  in  1  branch in EX resolved taken
pc_hold  out  1  PC keeps its value
loadad  out  1  IF/ID keeps its contents
jumpSuccess  out  1  IF/ID loads the nop encoding
idex_bubble  out  1  ID/EX loads control-zero bubble
mdu_go  out  1  one-cycle start strobe to MDU
mdu_busy  out  1  MDU result not yet valid
stall_cnt  out  PERF_W  saturating count of cycles with pc_hold=1

Behaviour:
- Reset (async, rst=1): state=RUN, cnt=0, stall_cnt=0. Outputs while rst=1: pc_hold=1, jumpSuccess=1, idex_bubble=1, loadad=0, mdu_go=0, mdu_busy=0.
- Control outputs are combinational from the current inputs and registered state, with zero-cycle latency. State, cnt and stall_cnt update on posedge clk.
- lu = ex_load & ex_wreg!=0 & ((id_use_rs & id_rs==ex_wreg) | (id_use_rt & id_rt==ex_wreg)).
- ms = id_mdu_read & mdu_busy; also id_mdu_start & mdu_busy (no back-to-back MDU ops).
- Priority per cycle, highest first:
  1. ex_br_taken: jumpSuccess=1, idex_bubble=1, pc_hold=0, loadad=0. lu, ms and id_jump are ignored.
  2. lu: pc_hold=1, loadad=1, idex_bubble=1, for exactly 1 cycle. The bubble advances the load to MEM, so lu drops next cycle.
  3. ms: pc_hold=1, loadad=1, idex_bubble=1, repeated every cycle while the condition holds.
  4. id_jump: jumpSuccess=1 (kill the fetched slot); pc_hold=0, idex_bubble=0.
  5. Otherwise all control outputs are 0.
- Accept rule: mdu_go = id_mdu_start & ~ex_br_taken & ~lu & ~mdu_busy & ~rst. An MDU op in ID that is flushed or stalled is not started.
- FSM:
  - RUN: mdu_busy=0. On mdu_go go to BUSY with cnt=MDU_LAT-1.
  - BUSY: mdu_busy=1. Each cycle cnt decrements; on cnt==1 go to RUN next edge. mdu_busy therefore stays high for exactly MDU_LAT-1 cycles after the mdu_go cycle.
  - cnt is 4 bits. It never wraps, because it is only decremented in BUSY and the exit happens at 1.
- ex_br_taken during BUSY: the FSM keeps counting. An MDU op already started is architecturally committed.
- stall_cnt increments on every posedge with pc_hold=1 and rst=0. It saturates at all-ones and does not wrap.
- Reset mid-BUSY: immediate return to RUN, mdu_busy=0, pending result discarded.

Decomposition:
- Shared package cpu_pkg: ST_RUN/ST_BUSY state encoding, NOP_INS encoding (6'b111111, 26'b0), MDU_LAT default.
- One sub-module mdu_tracker holds the FSM and cnt, with inputs go and outputs busy. The top level contains the hazard compare, the priority logic and stall_cnt.

Test Plan:
- lw $5 in EX (ex_load=1, ex_wreg=5), ID add reads rs=5 -> one cycle of pc_hold=loadad=idex_bubble=1, then all 0. stall_cnt goes 0->1.
- Same as above but ex_wreg=0 or id_use_rs=0 -> no stall.
- ex_br_taken=1 together with lu=1 and id_jump=1 -> jumpSuccess=1, idex_bubble=1, pc_hold=0, loadad=0. stall_cnt unchanged.
- MDU_LAT=4: id_mdu_start at cycle 0 -> mdu_go=1 at cycle 0, mdu_busy=1 for cycles 1..3. mfhi in ID at cycle 1 stalls cycles 1..3 and proceeds at cycle 4. stall_cnt=3.
- id_mdu_start with ex_br_taken=1 -> mdu_go=0, state stays RUN.
- rst asserted asynchronously mid-BUSY -> mdu_busy=0 and stall_cnt=0 immediately, jumpSuccess=1. After release, operation resumes from RUN. Also force stall_cnt to all-ones and stall -> value holds at all-ones.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS core pipeline control blocks:
// MDU tracker state encoding, the IF/ID nop encoding and the default MDU latency.
package cpu_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  localparam int          MDU_LAT_DEF = 4;
  localparam logic [31:0] NOP_INS     = {6'b111111, 26'b0};

  // True when a used source register names the given destination.
  function automatic logic src_match(input logic use_r, input logic [4:0] src,
                                     input logic [4:0] dst);
    return use_r && (src == dst);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the ID/EX pipeline stages and the hazard controller.
// master = pipeline side, slave = hazard_ctrl.
interface hazard_ctrl_if #(
  parameter int PERF_W = 16
);
  logic [4:0]        id_rs;
  logic [4:0]        id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic              id_jump;
  logic              id_mdu_start;
  logic              id_mdu_read;
  logic              ex_load;
  logic [4:0]        ex_wreg;
  logic              ex_br_taken;
  logic              pc_hold;
  logic              loadad;
  logic              jumpSuccess;
  logic              idex_bubble;
  logic              mdu_go;
  logic              mdu_busy;
  logic [PERF_W-1:0] stall_cnt;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_jump, id_mdu_start, id_mdu_read,
           ex_load, ex_wreg, ex_br_taken,
    input  pc_hold, loadad, jumpSuccess, idex_bubble, mdu_go, mdu_busy, stall_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_jump, id_mdu_start, id_mdu_read,
           ex_load, ex_wreg, ex_br_taken,
    output pc_hold, loadad, jumpSuccess, idex_bubble, mdu_go, mdu_busy, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl_mdu_tracker.sv
// Tracks the busy window of the multi-cycle multiply/divide unit: busy for
// MDU_LAT-1 cycles after the cycle in which go_i is asserted.
module mdu_tracker
  import cpu_pkg::*;
#(
  parameter int MDU_LAT = MDU_LAT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic go_i,
  output logic busy_o
);

  mdu_state_e state_q;
  logic [3:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (go_i) begin
            state_q <= ST_BUSY;
            cnt_q   <= 4'(MDU_LAT - 1);
          end
        end
        ST_BUSY: begin
          // A started op always completes; flushes do not abort the count.
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= ST_RUN;
        end
      endcase
    end
  end

  assign busy_o = (state_q == ST_BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use, MDU-busy and branch/jump handling for
// the IF/ID and ID/EX registers, plus a saturating stall-cycle counter.
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int MDU_LAT = MDU_LAT_DEF,
  parameter int PERF_W  = 16
) (
  input  logic           clk,
  input  logic           rst,
  hazard_ctrl_if.slave   hz
);

  logic              lu;
  logic              ms;
  logic              busy;
  logic              go;
  logic              pc_hold;
  logic              loadad;
  logic              jump_success;
  logic              idex_bubble;
  logic [PERF_W-1:0] stall_cnt_q;

  assign lu = hz.ex_load && (hz.ex_wreg != 5'd0) &&
              (src_match(hz.id_use_rs, hz.id_rs, hz.ex_wreg) ||
               src_match(hz.id_use_rt, hz.id_rt, hz.ex_wreg));

  assign ms = (hz.id_mdu_read || hz.id_mdu_start) && busy;

  // An MDU op is started only if it actually leaves ID this cycle.
  assign go = hz.id_mdu_start && !hz.ex_br_taken && !lu && !busy && !rst;

  // NOTE: every output gets a default at the top of the block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    pc_hold      = 1'b0;
    loadad       = 1'b0;
    jump_success = 1'b0;
    idex_bubble  = 1'b0;
    if (rst) begin
      pc_hold      = 1'b1;
      jump_success = 1'b1;
      idex_bubble  = 1'b1;
    end else if (hz.ex_br_taken) begin
      jump_success = 1'b1;
      idex_bubble  = 1'b1;
    end else if (lu || ms) begin
      pc_hold     = 1'b1;
      loadad      = 1'b1;
      idex_bubble = 1'b1;
    end else if (hz.id_jump) begin
      jump_success = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (pc_hold && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  mdu_tracker #(
    .MDU_LAT (MDU_LAT)
  ) u_mdu_tracker (
    .clk    (clk),
    .rst    (rst),
    .go_i   (go),
    .busy_o (busy)
  );

  assign hz.pc_hold     = pc_hold;
  assign hz.loadad      = loadad;
  assign hz.jumpSuccess = jump_success;
  assign hz.idex_bubble = idex_bubble;
  assign hz.mdu_go      = go;
  assign hz.mdu_busy    = busy;
  assign hz.stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by random
// stimulus, all compared against a cycle-indexed behavioural model.
module tb_hazard_ctrl;

  localparam int MDU_LAT   = 4;
  localparam int PERF_W    = 6;
  localparam int STALL_MAX = (1 << PERF_W) - 1;

  logic clk;
  logic rst;

  hazard_ctrl_if #(.PERF_W(PERF_W)) hz ();

  hazard_ctrl #(
    .MDU_LAT (MDU_LAT),
    .PERF_W  (PERF_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  // Model state: cycle index, cycle of the last accepted MDU start, stall count.
  int cyc    = 0;
  int go_cyc = -1000;
  int stall_m = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_outputs(output logic ph, output logic ld, output logic js,
                               output logic bub, output logic go, output logic busy);
    logic lu, ms;
    busy = (cyc > go_cyc) && (cyc <= go_cyc + MDU_LAT - 1);
    lu = hz.ex_load && (hz.ex_wreg != 0) &&
         ((hz.id_use_rs && hz.id_rs == hz.ex_wreg) ||
          (hz.id_use_rt && hz.id_rt == hz.ex_wreg));
    ms = (hz.id_mdu_read || hz.id_mdu_start) && busy;
    go = hz.id_mdu_start && !hz.ex_br_taken && !lu && !busy;
    ph = 0; ld = 0; js = 0; bub = 0;
    if (hz.ex_br_taken) begin
      js = 1; bub = 1;
    end else if (lu || ms) begin
      ph = 1; ld = 1; bub = 1;
    end else if (hz.id_jump) begin
      js = 1;
    end
  endtask

  task automatic set_idle();
    hz.id_rs = 0; hz.id_rt = 0; hz.id_use_rs = 0; hz.id_use_rt = 0;
    hz.id_jump = 0; hz.id_mdu_start = 0; hz.id_mdu_read = 0;
    hz.ex_load = 0; hz.ex_wreg = 0; hz.ex_br_taken = 0;
  endtask

  // Inputs are set before the call; outputs are checked at the negedge and the
  // model advances at the following posedge.
  task automatic run_cycle();
    logic ph, ld, js, bub, go, busy;
    @(negedge clk);
    model_outputs(ph, ld, js, bub, go, busy);
    check("pc_hold",     32'(hz.pc_hold),     32'(ph));
    check("loadad",      32'(hz.loadad),      32'(ld));
    check("jumpSuccess", 32'(hz.jumpSuccess), 32'(js));
    check("idex_bubble", 32'(hz.idex_bubble), 32'(bub));
    check("mdu_go",      32'(hz.mdu_go),      32'(go));
    check("mdu_busy",    32'(hz.mdu_busy),    32'(busy));
    check("stall_cnt",   32'(hz.stall_cnt),   32'(stall_m));
    @(posedge clk);
    if (go) go_cyc = cyc;
    if (ph && stall_m < STALL_MAX) stall_m++;
    cyc++;
    #1;
  endtask

  // Asserts reset mid-cycle (asynchronously) and checks the reset-time outputs.
  task automatic apply_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    check({tag, "_pc_hold"},   32'(hz.pc_hold),     32'd1);
    check({tag, "_jump"},      32'(hz.jumpSuccess), 32'd1);
    check({tag, "_bubble"},    32'(hz.idex_bubble), 32'd1);
    check({tag, "_loadad"},    32'(hz.loadad),      32'd0);
    check({tag, "_mdu_go"},    32'(hz.mdu_go),      32'd0);
    check({tag, "_mdu_busy"},  32'(hz.mdu_busy),    32'd0);
    check({tag, "_stall_cnt"}, 32'(hz.stall_cnt),   32'd0);
    go_cyc  = -1000;
    stall_m = 0;
    set_idle();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s_before;
    rst = 1'b1;
    set_idle();
    #1;
    apply_reset("reset");

    // Load-use on rs: one stall cycle, then the load has moved on.
    hz.ex_load = 1; hz.ex_wreg = 5; hz.id_rs = 5; hz.id_use_rs = 1;
    run_cycle();
    hz.ex_load = 0;
    run_cycle();
    check("lu_stall_cnt", 32'(hz.stall_cnt), 32'd1);

    // Load-use on rt.
    hz.ex_load = 1; hz.ex_wreg = 9; hz.id_rs = 1; hz.id_rt = 9; hz.id_use_rt = 1;
    run_cycle();
    set_idle();

    // No stall: destination $0, or matching rs not actually read.
    hz.ex_load = 1; hz.ex_wreg = 0; hz.id_rs = 0; hz.id_use_rs = 1;
    run_cycle();
    hz.ex_wreg = 5; hz.id_rs = 5; hz.id_use_rs = 0;
    run_cycle();
    set_idle();

    // Taken branch overrides load-use and jump.
    hz.ex_br_taken = 1; hz.ex_load = 1; hz.ex_wreg = 7; hz.id_rs = 7;
    hz.id_use_rs = 1; hz.id_jump = 1;
    s_before = stall_m;
    run_cycle();
    check("br_stall_cnt", 32'(hz.stall_cnt), 32'(s_before));
    set_idle();

    // Plain jump.
    hz.id_jump = 1;
    run_cycle();
    set_idle();

    // MDU start, then mfhi waits out the busy window.
    s_before = stall_m;
    hz.id_mdu_start = 1;
    run_cycle();
    hz.id_mdu_start = 0; hz.id_mdu_read = 1;
    repeat (4) run_cycle();
    set_idle();
    run_cycle();
    check("mdu_stalls", 32'(hz.stall_cnt) - 32'(s_before), 32'd3);

    // MDU start in the shadow of a taken branch is not accepted.
    hz.id_mdu_start = 1; hz.ex_br_taken = 1;
    run_cycle();
    set_idle();
    run_cycle();
    check("br_no_busy", 32'(hz.mdu_busy), 32'd0);

    // Reset in the middle of a busy window.
    hz.id_mdu_start = 1;
    run_cycle();
    set_idle();
    run_cycle();
    check("pre_rst_busy", 32'(hz.mdu_busy), 32'd1);
    apply_reset("mid_busy_rst");
    hz.id_mdu_start = 1;
    run_cycle();
    set_idle();
    repeat (MDU_LAT) run_cycle();

    // Counter saturation under a held stall condition.
    hz.ex_load = 1; hz.ex_wreg = 3; hz.id_rt = 3; hz.id_use_rt = 1;
    repeat (STALL_MAX + 8) run_cycle();
    check("stall_sat", 32'(hz.stall_cnt), 32'(STALL_MAX));
    set_idle();
    apply_reset("post_sat_rst");

    // Random traffic with a small register space so hazards are frequent.
    for (int i = 0; i < 400; i++) begin
      hz.id_rs        = 5'($urandom_range(0, 3));
      hz.id_rt        = 5'($urandom_range(0, 3));
      hz.id_use_rs    = 1'($urandom_range(0, 1));
      hz.id_use_rt    = 1'($urandom_range(0, 1));
      hz.id_jump      = ($urandom_range(0, 5) == 0);
      hz.id_mdu_start = ($urandom_range(0, 4) == 0);
      hz.id_mdu_read  = ($urandom_range(0, 3) == 0);
      hz.ex_load      = ($urandom_range(0, 2) == 0);
      hz.ex_wreg      = 5'($urandom_range(0, 3));
      hz.ex_br_taken  = ($urandom_range(0, 7) == 0);
      run_cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
